// File: rtl/vertex_submit_ctrl.sv
// Host-side triangle submission controller: nine staging words are snapshotted on
// a kick and issued as one 288-bit write into the rasteriser vertex FIFO.
module vertex_submit_ctrl #(
    parameter bit AUTO_KICK   = 1'b0,
    parameter int COUNT_WIDTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [3:0]   host_address,
    input  logic         host_write,
    input  logic [31:0]  host_writedata,
    input  logic         host_read,
    output logic [31:0]  host_readdata,
    output logic         host_waitrequest,
    output logic [287:0] vertex_data,
    output logic         vertex_data_valid,
    input  logic         vertex_data_full,
    output logic         busy
);
    typedef enum logic {IDLE, PENDING} state_t;

    localparam logic [3:0] A_LAST_WORD = 4'd8;
    localparam logic [3:0] A_CTRL      = 4'd9;
    localparam logic [3:0] A_STATUS    = 4'd10;

    state_t                 state;
    logic [8:0][31:0]       stage;
    logic [8:0][31:0]       pend;
    logic [8:0][31:0]       snap;
    logic [287:0]           pend_flat;
    logic [COUNT_WIDTH-1:0] count;
    logic [15:0]            count16;
    logic                   kick_req;
    logic                   wr_ok;
    logic                   clr;
    logic                   issue;
    logic                   unused_host_read;

    assign unused_host_read = host_read;

    assign kick_req = host_write &&
                      ((host_address == A_CTRL && host_writedata[0]) ||
                       (AUTO_KICK && host_address == A_LAST_WORD));
    assign host_waitrequest = kick_req && busy;
    // A stalled access has no side effects until the edge where it completes.
    assign wr_ok = host_write && !host_waitrequest;
    assign clr   = wr_ok && host_address == A_CTRL && host_writedata[1];
    assign issue = (state == PENDING) && !vertex_data_full;
    assign count16 = 16'(count);

    always_comb begin
        snap = stage;
        if (AUTO_KICK && host_address == A_LAST_WORD)
            snap[8] = host_writedata;
    end

    // Word 0 (a_x) lands in the most significant slot of the packet.
    always_comb begin
        pend_flat = '0;
        for (int i = 0; i < 9; i++)
            pend_flat[(8 - i) * 32 +: 32] = pend[i];
    end

    always_comb begin
        host_readdata = '0;
        if (host_address <= A_LAST_WORD)
            host_readdata = stage[host_address];
        else if (host_address == A_STATUS)
            host_readdata = {count16, 14'd0, vertex_data_full, busy};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            stage             <= '0;
            pend              <= '0;
            vertex_data       <= '0;
            vertex_data_valid <= 1'b0;
            busy              <= 1'b0;
            count             <= '0;
        end else begin
            vertex_data_valid <= 1'b0;
            if (wr_ok && host_address <= A_LAST_WORD)
                stage[host_address] <= host_writedata;
            case (state)
                IDLE: begin
                    if (kick_req) begin
                        pend  <= snap;
                        busy  <= 1'b1;
                        state <= PENDING;
                    end
                end
                PENDING: begin
                    if (!vertex_data_full) begin
                        vertex_data       <= pend_flat;
                        vertex_data_valid <= 1'b1;
                        busy              <= 1'b0;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Clear beats a coincident issue.
            if (clr)
                count <= '0;
            else if (issue)
                count <= count + COUNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_vertex_submit_ctrl.sv
// Scoreboard bench for vertex_submit_ctrl: one instance without and one with
// auto-kick (narrow counter), driven over a shared host bus with a select.
module tb_vertex_submit_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  ha = '0;
    logic        hw = 1'b0;
    logic        hr = 1'b0;
    logic [31:0] hd = '0;
    logic        full = 1'b0;
    logic        sel = 1'b0;

    logic [1:0][31:0]  rd;
    logic [1:0]        wrq;
    logic [1:0][287:0] vd;
    logic [1:0]        vv;
    logic [1:0]        bsy;

    localparam int CW [2] = '{16, 4};
    localparam bit AK [2] = '{1'b0, 1'b1};

    always #5 clock = ~clock;

    vertex_submit_ctrl #(.AUTO_KICK(1'b0), .COUNT_WIDTH(16)) dut_a (
        .clock(clock), .reset(reset), .host_address(ha), .host_write(hw && !sel),
        .host_writedata(hd), .host_read(hr && !sel), .host_readdata(rd[0]),
        .host_waitrequest(wrq[0]), .vertex_data(vd[0]), .vertex_data_valid(vv[0]),
        .vertex_data_full(full), .busy(bsy[0]));

    vertex_submit_ctrl #(.AUTO_KICK(1'b1), .COUNT_WIDTH(4)) dut_b (
        .clock(clock), .reset(reset), .host_address(ha), .host_write(hw && sel),
        .host_writedata(hd), .host_read(hr && sel), .host_readdata(rd[1]),
        .host_waitrequest(wrq[1]), .vertex_data(vd[1]), .vertex_data_valid(vv[1]),
        .vertex_data_full(full), .busy(bsy[1]));

    // Reference model: staging image, queue of accepted packets, issue counter.
    logic [31:0]  stg [2][9];
    logic [287:0] exq [2][$];
    int           excyc [2][$];
    int           cnt [2];
    bit           clrp [2];
    int           cyc = 0;
    logic         full_q = 1'b0;
    int           checks = 0;
    int           fails = 0;
    bit           rdone = 1'b0;

    task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 9; i++) stg[d][i] = '0;
            exq[d].delete();
            excyc[d].delete();
            cnt[d] = 0;
            clrp[d] = 1'b0;
        end
    endtask

    always @(posedge clock) begin
        cyc    <= cyc + 1;
        full_q <= full;
    end

    // Monitor: a packet accepted on an earlier edge issues on the first edge with full low.
    always @(negedge clock) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                bit ev;
                logic [287:0] e;
                ev = exq[d].size() > 0 && excyc[d][0] < cyc && !full_q;
                chk($sformatf("valid%0d", d), {287'd0, vv[d]}, {287'd0, ev});
                if (ev) begin
                    e = exq[d].pop_front();
                    void'(excyc[d].pop_front());
                    if (vv[d]) chk($sformatf("data%0d", d), vd[d], e);
                    cnt[d] = (cnt[d] + 1) % (1 << CW[d]);
                end
                if (clrp[d]) begin
                    cnt[d] = 0;
                    clrp[d] = 1'b0;
                end
                chk($sformatf("busy%0d", d), {287'd0, bsy[d]}, {287'd0, exq[d].size() != 0});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input int d, input logic [3:0] a, input logic [31:0] v);
        bit kick;
        int n;
        logic [287:0] pk;
        kick = (a == 4'd9 && v[0]) || (AK[d] && a == 4'd8);
        sel = d[0]; ha = a; hd = v; hw = 1'b1;
        n = 0;
        forever begin
            @(negedge clock); #1;
            chk($sformatf("waitreq%0d", d), {287'd0, wrq[d]},
                {287'd0, kick && exq[d].size() != 0});
            if (!wrq[d]) break;
            n++;
            if (n > 200) begin
                chk("wait_timeout", 288'd1, 288'd0);
                break;
            end
        end
        @(posedge clock); #1;
        hw = 1'b0;
        if (kick) begin
            pk = {stg[d][0], stg[d][1], stg[d][2], stg[d][3], stg[d][4],
                  stg[d][5], stg[d][6], stg[d][7], (a == 4'd8) ? v : stg[d][8]};
            exq[d].push_back(pk);
            excyc[d].push_back(cyc);
        end
        if (a <= 4'd8) stg[d][a] = v;
        if (a == 4'd9 && v[1]) clrp[d] = 1'b1;
    endtask

    task automatic rd_chk(input int d, input logic [3:0] a);
        logic [31:0] e;
        logic [15:0] c16;
        sel = d[0]; ha = a; hr = 1'b1;
        @(negedge clock); #1;
        c16 = 16'(cnt[d]);
        if (a <= 4'd8) e = stg[d][a];
        else if (a == 4'd10) e = {c16, 14'd0, full, exq[d].size() != 0};
        else e = '0;
        chk($sformatf("read%0d_a%0d", d, a), {256'd0, rd[d]}, {256'd0, e});
        @(posedge clock); #1;
        hr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_vdata", vd[0], 288'd0);
        chk("rst_valid", {286'd0, vv}, 288'd0);
        for (int a = 0; a < 16; a++) rd_chk(0, 4'(a));
        rd_chk(1, 4'd10);

        // Basic submit: words 1..9, then kick.
        for (int i = 0; i < 9; i++) wr(0, 4'(i), 32'(i + 1));
        wr(0, 4'd9, 32'd1);
        idle(3);
        chk("a_x", {256'd0, vd[0][287:256]}, 288'd1);
        chk("c_col", {256'd0, vd[0][31:0]}, 288'd9);
        rd_chk(0, 4'd10);

        // Held full: packet waits, second kick stalls until drain then issues.
        full = 1'b1;
        wr(0, 4'd9, 32'd1);
        idle(20);
        rd_chk(0, 4'd10);
        fork
            wr(0, 4'd9, 32'd1);
            begin repeat (20) @(posedge clock); #1 full = 1'b0; end
        join
        idle(4);
        rd_chk(0, 4'd10);

        // Staging rewrite while busy only affects the next packet.
        full = 1'b1;
        wr(0, 4'd9, 32'd1);
        wr(0, 4'd0, 32'hAAAA);
        idle(3);
        full = 1'b0;
        idle(2);
        wr(0, 4'd9, 32'd1);
        idle(3);
        rd_chk(0, 4'd0);

        // Auto-kick on word 8.
        wr(1, 4'd8, 32'h00FF00FF);
        idle(3);
        chk("auto_c_col", {256'd0, vd[1][31:0]}, {256'd0, 32'h00FF00FF});
        rd_chk(1, 4'd10);

        // Narrow counter wraps back to zero after 16 issues.
        for (int i = 0; i < 15; i++) begin
            wr(1, 4'd9, 32'd1);
            idle(2);
        end
        rd_chk(1, 4'd10);

        // Clear coinciding with an issue, then kick+clear in one write.
        wr(0, 4'd9, 32'd1);
        wr(0, 4'd9, 32'd2);
        idle(2);
        rd_chk(0, 4'd10);
        wr(0, 4'd9, 32'd3);
        idle(3);
        rd_chk(0, 4'd10);

        // Randomized traffic with full toggling underneath.
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    int d;
                    int op;
                    d = int'($urandom_range(0, 1));
                    op = int'($urandom_range(0, 7));
                    case (op)
                        0, 1, 2, 3: wr(d, 4'($urandom_range(0, 8)), $urandom);
                        4: wr(d, 4'd9, $urandom | 32'd1);
                        5: rd_chk(d, 4'($urandom_range(0, 15)));
                        6: wr(d, 4'($urandom_range(11, 15)), $urandom);
                        default: idle(int'($urandom_range(1, 4)));
                    endcase
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clock); #1;
                    full = ($urandom_range(0, 2) == 0);
                end
            end
        join
        full = 1'b0;
        idle(4);
        for (int a = 9; a < 16; a++) rd_chk(0, 4'(a));
        rd_chk(1, 4'd10);

        // Reset while a packet is pending: it is dropped, no valid follows.
        full = 1'b1;
        wr(0, 4'd9, 32'd1);
        idle(2);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        chk("rst_busy", {287'd0, bsy[0]}, 288'd0);
        chk("rst_valid2", {286'd0, vv}, 288'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        full = 1'b0;
        idle(5);
        rd_chk(0, 4'd0);
        rd_chk(0, 4'd8);
        rd_chk(0, 4'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
